// File: rtl/bcd_pkg.sv
// Shared widths, adjust constants and state encoding for the bcd2bin converter.
// DIGIT_MAX exists only when BCD2BIN_DIGIT_CHECK_EN is defined.
package bcd_pkg;

  localparam int N_DIGITS = 4;
  localparam int DIGIT_W  = 4;
  localparam int BCD_W    = N_DIGITS * DIGIT_W;
  localparam int BIN_W    = 14;
  localparam int N_SHIFTS = 14;
  localparam int CNT_W    = 4;

  localparam logic [DIGIT_W-1:0] BCD_ADJ    = 4'd3;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd7;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP   = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/bcd2bin_if.sv
// Request/result bundle between digit-entry logic (master) and the bcd2bin
// converter (slave).
interface bcd2bin_if;
  import bcd_pkg::*;

  logic             start;
  logic [3:0]       bcd3;
  logic [3:0]       bcd2;
  logic [3:0]       bcd1;
  logic [3:0]       bcd0;
  logic             ready;
  logic             done_tick;
  logic [BIN_W-1:0] bin;
  logic             err;

  modport master (
    output start, bcd3, bcd2, bcd1, bcd0,
    input  ready, done_tick, bin, err
  );

  modport slave (
    input  start, bcd3, bcd2, bcd1, bcd0,
    output ready, done_tick, bin, err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the reverse double-dabble correction: a digit that picked
// up a half-ten from its neighbour (value above 7) is pulled back by 3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  assign d_o = (d_i > ADJ_THRESH) ? d_i - BCD_ADJ : d_i;

endmodule

// File: rtl/bcd2bin.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// Define BCD2BIN_DIGIT_CHECK_EN to reject digits above 9 and drive err.
module bcd2bin
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  bcd2bin_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;

  logic [BCD_W-1:0] bcd_in;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_shift;

  assign bcd_in = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};

  // The BCD LSB falls into the binary MSB on every shift.
  assign {bcd_shift, bin_shift} = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .d_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic                err_q, err_d;
  logic [N_DIGITS-1:0] digit_bad;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_chk
    assign digit_bad[g] = (bcd_in[g*DIGIT_W +: DIGIT_W] > DIGIT_MAX);
  end
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    n_d     = n_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    err_d   = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          n_d     = CNT_W'(N_SHIFTS);
          state_d = ST_OP;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_d   = 1'b0;
          if (|digit_bad) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end

      ST_OP: begin
        bcd_d = bcd_adj;
        bin_d = bin_shift;
        n_d   = n_q - CNT_W'(1);
        if (n_q == CNT_W'(1)) state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.done_tick = (state_q == ST_DONE);
  assign bus.bin       = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin: expected results are queued at start acceptance
// and compared by a monitor whenever done_tick is seen.
module tb_bcd2bin;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  bcd2bin_if bus();

  bcd2bin dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] bcd_val(input logic [3:0] d3, d2, d1, d0);
    return 14'(int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0));
  endfunction

  // Drives one start cycle once the DUT is idle; optionally queues the result.
  task automatic do_start(input logic [3:0] d3, d2, d1, d0, input bit push,
                          input int lat, input logic [13:0] exp_bin, input logic exp_err);
    exp_t e;
    int b = 0;
    while (bus.ready !== 1'b1 && b < 100) begin
      step();
      b++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.bcd3 = d3;
    bus.bcd2 = d2;
    bus.bcd1 = d1;
    bus.bcd0 = d0;
    if (push) begin
      e.bin = exp_bin;
      e.err = exp_err;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    step();
    bus.start = 1'b0;
    bus.bcd3 = 4'($urandom);
    bus.bcd2 = 4'($urandom);
    bus.bcd1 = 4'($urandom);
    bus.bcd0 = 4'($urandom);
  endtask

  task automatic wait_done();
    int b = 0;
    while (bus.done_tick !== 1'b1 && b < 40) begin
      step();
      b++;
    end
    check("done_wait", 32'(bus.done_tick), 32'd1);
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while (sb.size() != 0 && b < 100) begin
      step();
      b++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard side: every done_tick must match the oldest queued conversion.
  initial begin
    exp_t e;
    forever begin
      step();
      if (reset !== 1'b1 && bus.done_tick === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'(bus.done_tick), 32'd0);
        end else begin
          e = sb.pop_front();
          check("result_bin", 32'(bus.bin), 32'(e.bin));
          check("result_err", 32'(bus.err), 32'(e.err));
          check("result_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    logic [3:0] r3, r2, r1, r0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.bcd3 = 4'd0;
    bus.bcd2 = 4'd0;
    bus.bcd1 = 4'd0;
    bus.bcd0 = 4'd0;
    step();
    step();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done_tick", 32'(bus.done_tick), 32'd0);
    check("rst_bin", 32'(bus.bin), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    step();

    // All zeros, with ready low once the conversion is under way.
    do_start(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 15, 14'd0, 1'b0);
    check("ready_low_in_op", 32'(bus.ready), 32'd0);
    drain("drain_zero");

    // Maximum value, then bin must hold in idle.
    do_start(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 15, 14'h270F, 1'b0);
    drain("drain_9999");
    step();
    step();
    step();
    check("bin_hold_idle", 32'(bus.bin), 32'h270F);

    // 1234 with start pulses in op and done, then back-to-back 0010.
    do_start(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 15, 14'd1234, 1'b0);
    step();
    step();
    step();
    bus.start = 1'b1;
    bus.bcd3 = 4'd0;
    bus.bcd2 = 4'd0;
    bus.bcd1 = 4'd0;
    bus.bcd0 = 4'd1;
    step();
    bus.start = 1'b0;
    wait_done();
    bus.start = 1'b1;
    bus.bcd3 = 4'd9;
    bus.bcd2 = 4'd9;
    bus.bcd1 = 4'd9;
    bus.bcd0 = 4'd9;
    step();
    check("ready_first_idle", 32'(bus.ready), 32'd1);
    do_start(4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 15, 14'd10, 1'b0);
    drain("drain_b2b");

    // start held high: one conversion every 16 cycles.
    bus.bcd3 = 4'd5;
    bus.bcd2 = 4'd0;
    bus.bcd1 = 4'd0;
    bus.bcd0 = 4'd0;
    bus.start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.ready === 1'b1) sb.push_back('{bin: 14'd5000, err: 1'b0, cyc: cyc + 15});
      step();
    end
    bus.start = 1'b0;
    drain("drain_continuous");

    // Reset in the middle of a conversion.
    do_start(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 15, 14'd0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("bin_moving_in_op", 32'(bus.bin != 14'd0), 32'd1);
    reset = 1'b1;
    step();
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_bin", 32'(bus.bin), 32'd0);
    check("midrst_done_tick", 32'(bus.done_tick), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    do_start(4'd0, 4'd4, 4'd2, 4'd0, 1'b1, 15, 14'd420, 1'b0);
    drain("drain_after_reset");

    // A few random valid numbers against the decimal weighting model.
    for (int i = 0; i < 4; i++) begin
      r3 = 4'($urandom_range(0, 9));
      r2 = 4'($urandom_range(0, 9));
      r1 = 4'($urandom_range(0, 9));
      r0 = 4'($urandom_range(0, 9));
      do_start(r3, r2, r1, r0, 1'b1, 15, bcd_val(r3, r2, r1, r0), 1'b0);
    end
    drain("drain_random");

`ifdef BCD2BIN_DIGIT_CHECK_EN
    do_start(4'd1, 4'hA, 4'd0, 4'd0, 1'b1, 1, 14'd0, 1'b1);
    step();
    step();
    check("err_hold", 32'(bus.err), 32'd1);
    check("err_bin_zero", 32'(bus.bin), 32'd0);
    do_start(4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 15, 14'd7, 1'b0);
    drain("drain_digit_check");
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
# bcd2bin

Sequential BCD-to-binary converter: the inverse of the binary-to-BCD block. It takes four packed BCD digits (0000–9999) and produces the 14-bit binary value. It uses a reverse double-dabble datapath: shift right one bit per cycle, then subtract 3 from any digit above 7. It sits between digit-entry logic (keypad / switch decoders) and binary arithmetic in the reaction-timer datapath, with the same start/ready/done_tick handshake as the forward converter.

## Interface
- No parameters; widths are fixed by package constants (4 digits, 14-bit result, 14 shifts).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock, synchronous active-high reset.
- start  input  1  request; sampled only while ready=1.
- bcd3, bcd2, bcd1, bcd0  input  4 each  BCD digits, bcd3 = thousands; sampled in the start cycle only.
- ready  output  1  high in idle state (combinational from state).
- done_tick  output  1  one-cycle pulse in done state.
- bin  output  14  converted value, registered.
- err  output  1  invalid-digit flag, registered (see Configuration).

## Operation
- States: idle, op, done (2-bit encoding from package); any other encoding goes to idle.
- idle: ready=1. On start=1:
  - load the 16-bit BCD register with {bcd3,bcd2,bcd1,bcd0};
  - clear the bin register;
  - set counter n=14;
  - go to op.
- idle with start=0: hold; bin and err keep their last values.
- op, each cycle:
  - form {bcd_reg,bin_reg} >> 1; the BCD LSB enters the bin MSB;
  - then, per digit of the shifted BCD value, if the digit > 7, subtract 3 (4-bit, no borrow between digits);
  - n decrements; when n reaches 0, go to done. The adjustment on the last shift is harmless.
- done: done_tick=1; next state idle.
- start is ignored outside idle. The digit inputs need not be held after the start cycle.
- Result: 14 bits; max 9999 = 14'h270F, so there is no overflow.
- bin is only meaningful when done_tick=1 or in idle after a completed conversion. Intermediate shift values appear on bin during op.
- Reset (any state, including mid-op): state=idle, bin=0, err=0, n=0, BCD register=0. ready=1 in the first cycle after reset.

## Timing
- Start accepted at edge T (start=1, state idle).
- Edges T+1..T+14: op.
- Cycle after edge T+14: state done; done_tick=1 and bin is final.
- Edge T+15 returns to idle; ready=1. Total latency is 15 cycles from accept to done_tick.
- Back-to-back: start may be asserted in the first idle cycle after done; the next done_tick comes 15 cycles later.
- start asserted during done is ignored; it is not queued.

## Configuration
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined: in the start cycle, if any digit > 9, the block skips op and goes directly to done. In that case:
  - bin is cleared to 0;
  - err is set to 1 and held until the next accepted start or reset;
  - done_tick fires 1 cycle after accept.
- Defined, valid start: err is cleared.
- Not defined: err is tied to 0 and no check is done. Invalid digits are converted by the algorithm unchanged, and the result is unspecified but deterministic.

## Structure
- Package bcd_pkg holds:
  - state localparams (idle/op/done);
  - digit count 4, binary width 14, shift count 14;
  - BCD_ADJ=3 and the adjust threshold 7.
- Sub-module bcd_digit_adj: combinational 4-bit, out = (in > 7) ? in - 3 : in. Instantiated four times.

## Test plan
- Digits 0,0,0,0 -> done_tick 15 cycles after accept; bin=0; err=0.
- Digits 9,9,9,9 -> bin=14'h270F (9999).
- Digits 1,2,3,4 -> bin=1234. A second start the cycle after done with 0,0,1,0 -> bin=10; exactly one done_tick per conversion.
- start held high continuously with digits 5,0,0,0 -> a conversion every 16 cycles, bin=5000. Start pulses during op/done do not restart or extend the conversion.
- Reset asserted at op cycle 7 -> next cycle state idle, ready=1, bin=0, no done_tick. A fresh start with 0,4,2,0 -> bin=420.
- With BCD2BIN_DIGIT_CHECK_EN defined:
  - digits 1,A,0,0 -> done_tick 1 cycle after accept, err=1, bin=0;
  - then 0,0,0,7 -> err=0, bin=7.
